// File: rtl/spi_slave_if_pkg.sv
// Shared types and constants for the SPI slave byte interface.
package spi_pkg;
  localparam int                BYTE_W         = 8;
  localparam logic [BYTE_W-1:0] SPI_DEFAULT_TX = 8'hFF;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;
endmodule

// File: rtl/spi_slave_if.sv
// Oversampling SPI slave (all CPOL/CPHA modes) with byte-wide valid/ready
// registers. Define SPI_SLAVE_OVR_EN to add the sticky rx_ovr flag and ovr_clr.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] DEFAULT_TX  = SPI_DEFAULT_TX
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic              CPOL,
  input  logic              CPHA,
  input  logic              SCLK,
  input  logic              MOSI,
  input  logic              SS_N,
  output logic              MISO,
  output logic              MISO_OE,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_rd,
  output logic              busy
`ifdef SPI_SLAVE_OVR_EN
  ,
  output logic              rx_ovr,
  input  logic              ovr_clr
`endif
);
  logic w_sclk_s, w_sclk_rise, w_sclk_fall;
  logic w_ss_s, w_ss_rise_unused, w_ss_fall;
  logic w_mosi_s, w_mosi_rise_unused, w_mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .i_d(SCLK),
    .o_q(w_sclk_s), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .i_d(SS_N),
    .o_q(w_ss_s), .o_rise(w_ss_rise_unused), .o_fall(w_ss_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .i_d(MOSI),
    .o_q(w_mosi_s), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
  );

  spi_state_e        r_state;
  logic [2:0]        r_bit_cnt;
  logic [BYTE_W-2:0] r_rx_shift;
  logic [BYTE_W-1:0] r_tx_shift;
  logic [BYTE_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic [BYTE_W-1:0] r_tx_buf;
  logic              r_tx_full;

  logic w_lead, w_trail, w_run, w_sample, w_shift, w_enter, w_reload, w_complete;
  logic [BYTE_W-1:0] w_next_tx;

  assign w_lead     = CPOL ? w_sclk_fall : w_sclk_rise;
  assign w_trail    = CPOL ? w_sclk_rise : w_sclk_fall;
  assign w_run      = (r_state == ACTIVE) && !w_ss_s;
  assign w_sample   = w_run && (CPHA ? w_trail : w_lead);
  assign w_shift    = w_run && (CPHA ? w_lead : w_trail);
  assign w_enter    = (r_state == IDLE) && w_ss_fall;
  assign w_complete = w_sample && (r_bit_cnt == 3'd7);
  // A shift edge at bit_cnt==0 is the byte boundary: CPHA=0 reloads there,
  // CPHA=1 already reloaded on the last sample and must hold bit 7.
  assign w_reload   = w_enter || (CPHA && w_complete) ||
                      (!CPHA && w_shift && (r_bit_cnt == 3'd0));
  assign w_next_tx  = r_tx_full ? r_tx_buf : DEFAULT_TX;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state    <= IDLE;
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= '0;
      r_tx_shift <= DEFAULT_TX;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_buf   <= '0;
      r_tx_full  <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        if (w_enter) begin
          r_state   <= ACTIVE;
          r_bit_cnt <= 3'd0;
        end
      end else if (w_ss_s) begin
        r_state <= IDLE;
      end

      if (w_sample) begin
        r_rx_shift <= {r_rx_shift[BYTE_W-3:0], w_mosi_s};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
      end

      if (w_complete) begin
        r_rx_data  <= {r_rx_shift, w_mosi_s};
        r_rx_valid <= 1'b1;
      end else if (rx_rd) begin
        r_rx_valid <= 1'b0;
      end

      if (w_reload) begin
        r_tx_shift <= w_next_tx;
      end else if (w_shift && (r_bit_cnt != 3'd0)) begin
        r_tx_shift <= {r_tx_shift[BYTE_W-2:0], 1'b0};
      end

      // Accept and consume are exclusive: accept needs an empty buffer.
      if (w_reload && r_tx_full) begin
        r_tx_full <= 1'b0;
      end else if (tx_valid && !r_tx_full) begin
        r_tx_full <= 1'b1;
        r_tx_buf  <= tx_data;
      end
    end
  end

`ifdef SPI_SLAVE_OVR_EN
  logic r_rx_ovr;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rx_ovr <= 1'b0;
    end else if (w_complete && r_rx_valid && !rx_rd) begin
      r_rx_ovr <= 1'b1;
    end else if (ovr_clr) begin
      r_rx_ovr <= 1'b0;
    end
  end

  assign rx_ovr = r_rx_ovr;
`endif

  assign MISO     = r_tx_shift[BYTE_W-1];
  assign MISO_OE  = (r_state == ACTIVE);
  assign busy     = (r_state == ACTIVE);
  assign tx_ready = !r_tx_full;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

Byte-oriented SPI slave interface that sits on the far end of the link driven by the team's SPI master. It captures MOSI into bytes and returns a response byte on MISO in all four CPOL/CPHA modes. It oversamples the external SCLK/MOSI/SS_N with the system clock. Received bytes and transmit bytes reach local logic through simple valid/ready registers.

## Interface
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers; minimum 2.
- DEFAULT_TX, 8'hFF, byte shifted out when no transmit byte is buffered.

- S_AXI_ACLK  in  1  system clock; all logic is on its rising edge.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- CPOL  in  1  SCLK idle level; must be static while SS_N is low.
- CPHA  in  1  0 = sample on leading edge, 1 = sample on trailing edge; must be static while SS_N is low.
- SCLK  in  1  external serial clock, asynchronous.
- MOSI  in  1  external serial data in, MSB first.
- SS_N  in  1  external slave select, active-low.
- MISO  out  1  serial data out, MSB first; always equals tx_shift[7].
- MISO_OE  out  1  tristate enable; 1 only in ACTIVE.
- tx_data  in  8  next response byte.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmit buffer is empty.
- rx_data  out  8  last received byte.
- rx_valid  out  1  level signal; set when a byte completes.
- rx_rd  in  1  one-cycle pulse that clears rx_valid.
- busy  out  1  1 while in ACTIVE.
- rx_ovr, ovr_clr  out/in  1  overrun flag and its clear; present only under SPI_SLAVE_OVR_EN.

## Operation
- Synchronizers: SCLK, MOSI and SS_N each pass through SYNC_STAGES flops.
  - SS_N sync resets to 1; SCLK sync resets to 0.
  - Edges are detected on the synchronized SCLK and SS_N.
- Edge naming: the leading edge is the transition away from the CPOL level; the trailing edge is the return to it.
  - CPHA=0: sample on leading, shift on trailing.
  - CPHA=1: shift on leading, sample on trailing.
- FSM IDLE:
  - On a synchronized SS_N fall, go to ACTIVE.
  - On entry to ACTIVE: bit_cnt<=0, load tx_shift.
- FSM ACTIVE:
  - On each sample edge: rx_shift<={rx_shift[6:0],mosi_s}, bit_cnt+1 (mod 8).
  - On the 8th sample edge: rx_data<={rx_shift[6:0],mosi_s}, rx_valid<=1.
- Leaving ACTIVE: a synchronized SS_N high returns the FSM to IDLE from any bit position.
  - The partial byte is discarded and no rx_valid is generated.
  - tx_shift is not reloaded.
- tx_shift load: tx_shift takes tx_buf if the buffer is full (the buffer then empties); otherwise it takes DEFAULT_TX.
- Byte-boundary reload:
  - CPHA=0: reload on the trailing edge that follows the 8th sample.
  - CPHA=1: reload on the 8th sample edge; the next leading edge does not shift, so bit 7 stays on MISO.
- Shifting outside reload: tx_shift<<1 on every other shift edge.
- Transmit handshake: tx_buf is accepted when tx_valid&&tx_ready, and is accepted in IDLE too.
  - If acceptance and a reload occur in the same cycle, the reload sees the old (empty) buffer and loads DEFAULT_TX; the new byte stays buffered.
- Receive handshake:
  - If rx_rd and a byte completion occur in the same cycle, completion wins and rx_valid stays 1.
  - A completion while rx_valid=1 overwrites rx_data.

## Timing
- Reset values: MISO=DEFAULT_TX[7], MISO_OE=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, rx_ovr=0; tx_shift=DEFAULT_TX, FSM=IDLE.
- Latency from a raw SCLK/SS_N edge to the internal event: SYNC_STAGES+1 clocks.
  - MISO updates on the next clock after the event.
  - rx_valid rises on the next clock after the event.
- Minimum SCLK half-period: 2*SYNC_STAGES+4 clocks. The master's 50-clock half-period meets this.
- tx_ready falls on the clock after acceptance and rises on the clock after the buffer is consumed.
- Reset asserted mid-byte: immediate return to the reset values; no output glitches beyond the reset values.

## Configuration
- SPI_SLAVE_OVR_EN defined:
  - rx_ovr and ovr_clr ports exist.
  - rx_ovr is sticky; it is set by a byte completion while rx_valid=1 and not cleared by rx_rd in the same cycle.
  - ovr_clr clears rx_ovr; a simultaneous set wins.
- SPI_SLAVE_OVR_EN undefined: the ports and the flag are absent, and overwrite behaviour is unchanged.

## Structure
- Package spi_pkg:
  - FSM state enum (IDLE, ACTIVE).
  - Byte width constant (8).
  - Default DEFAULT_TX value.
- Sub-module spi_sync_edge: parameterized synchronizer with rise/fall pulse outputs. It is instanced for SCLK and SS_N; MOSI uses its data output only.

## Test plan
- Mode 0, master sends 8'hA5, tx_buf=8'h3C preloaded → rx_data=8'hA5 with rx_valid=1; master receives 8'h3C; tx_ready returns to 1.
- Modes 1, 2 and 3, master sends 8'h96 with no tx byte buffered → rx_data=8'h96; master receives 8'hFF.
- Two back-to-back bytes 8'h01 then 8'h02 in mode 3 with tx bytes 8'h11 and 8'h22 → rx_valid twice, rx_data ends at 8'h02; master receives 8'h11 then 8'h22.
- SS_N raised after 5 bits, then a full byte 8'h7E → no rx_valid for the aborted byte; rx_data=8'h7E afterwards.
- Two bytes with no rx_rd → rx_data holds the second byte; rx_ovr=1 under SPI_SLAVE_OVR_EN; ovr_clr clears it.
- Reset asserted mid-byte in mode 0 → all outputs at their reset values; the next full byte 8'hC3 is received correctly.
